data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Backing data memory that answers the direct-mapped data cache on its refill/write side.
- Accepts one request at a time over a valid/ready handshake.
  - Reads return one 4-word cache block as a 4-beat burst after a fixed access latency.
  - Writes store one 32-bit word and return a single completion beat.
- Models main-memory timing so cache miss penalties are realistic in simulation.

Parameters:
- ADDR_W, 15, word address width (32K words).
- DATA_W, 32, data word width.
- BURST_LEN, 4, words per read burst (cache block size); power of two.
- LATENCY, 4, cycles from request acceptance to first response beat; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = single-word write, 0 = block read.
- req_addr  in  ADDR_W  word address; for reads, low log2(BURST_LEN) bits ignored (block-aligned).
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  consumer accepts beat.
- rsp_data  out  DATA_W  read word; 0 on write completion.
- rsp_last  out  1  final beat of the response.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_last=0.
  - Latency counter and beat counter cleared.
  - Storage array is not reset; contents are unknown until written.
- Acceptance: a request is accepted on a rising edge with req_valid && req_ready. Request fields are sampled only on that edge.
- States:
  - IDLE: req_ready=1.
    - Accepted read: latch base = req_addr with low bits cleared, go to WAIT.
    - Accepted write: mem[req_addr] <= req_wdata on the same edge, go to WAIT.
  - WAIT: req_ready=0. Counter runs LATENCY-1 cycles, so the first rsp_valid is asserted exactly LATENCY cycles after the accept edge.
    - Read: go to BURST.
    - Write: go to WACK.
  - BURST: rsp_valid=1, rsp_data=mem[base + beat], beat starts at 0.
    - On rsp_valid && rsp_ready: beat increments.
    - rsp_last=1 when beat == BURST_LEN-1.
    - Handshake on the last beat returns to IDLE; req_ready is high the following cycle.
    - If rsp_ready is low, rsp_valid/rsp_data/rsp_last hold stable.
  - WACK: rsp_valid=1, rsp_last=1, rsp_data=0. Handshake returns to IDLE.
- Address arithmetic:
  - Beat address = {base[ADDR_W-1:log2(BURST_LEN)], beat}. It never carries into upper bits.
  - The top block (0x7FFC..0x7FFF) is served normally, with no wrap to 0.
- Throughput: back-to-back requests are separated by at least one IDLE cycle. Peak read rate is BURST_LEN words per LATENCY+BURST_LEN+1 cycles.
- Read-after-write: a read accepted after a write's WACK handshake returns the new data.
- Outputs are registered; no combinational path from req_* or rsp_ready to any output.
- Reset mid-operation (WAIT/BURST/WACK):
  - Transaction aborted; no further beats.
  - A write already committed on its accept edge stays written.
- req_valid while not ready is ignored; no queuing.
- LATENCY=1: WAIT lasts zero extra cycles; the first beat is valid on the cycle after acceptance.

Decomposition:
- Shared package mem_pkg:
  - ADDR_W, DATA_W, BURST_LEN constants.
  - BEAT_W = log2(BURST_LEN).
  - State enum {IDLE, WAIT, BURST, WACK}.
  - Block-base helper function.
- One sub-module, data_mem_array:
  - 2^ADDR_W x DATA_W storage.
  - One synchronous write port, one asynchronous read port.
- FSM and counters stay in data_mem_responder.

Test Plan:
- Reset/idle: assert rst mid-cycle with no clock → req_ready=1, rsp_valid=0, rsp_data=0, rsp_last=0 immediately.
- Write then read, LATENCY=4, rsp_ready=1:
  - Writes 0x0100..0x0103 ← 0xA0,0xA1,0xA2,0xA3, each with one WACK beat 4 cycles after accept (rsp_data=0, rsp_last=1).
  - Read req_addr=0x0102 → beats 0xA0,0xA1,0xA2,0xA3 on cycles T+4..T+7, rsp_last only on the 4th beat, req_ready back at T+8.
- Backpressure: same read with rsp_ready low for 3 cycles on beat 1 → beat 1 held stable with 0xA1 for those cycles; total 4 beats, no loss or duplication.
- Top block: write 0x7FFF ← 0xDEADBEEF, read 0x7FFD → 4th beat 0xDEADBEEF with rsp_last=1; the beat-address sequence stays within 0x7FFC..0x7FFF.
- Reset mid-burst: assert rst after beat 1 → rsp_valid=0 at once, req_ready=1; a fresh read of 0x0100 returns 0xA0..0xA3 correctly.
- Ignored request and LATENCY=1: req_valid held during BURST does not start a new transaction. With LATENCY=1 rebuilt, read 0x0100 → first beat valid on the cycle after accept.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and block-address helper for the
// backing data memory that serves the data cache refill/write port.
package mem_pkg;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;
  localparam int BEAT_W    = $clog2(BURST_LEN);
  localparam int BLK_W     = ADDR_W - BEAT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_WACK  = 2'd3
  } state_e;

  // Block number of a word address: the beat-offset bits are dropped.
  function automatic logic [BLK_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:BEAT_W];
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module data_mem_array #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write port commits on the rising edge.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Main-memory model answering the data cache: 4-word read bursts and
// single-word writes, each after a fixed access latency.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last
);

  localparam logic [3:0]        LAT_INIT  = 4'(LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_ZERO = {BEAT_W{1'b0}};

  state_e             state_q, state_d;
  logic [3:0]         lat_q, lat_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [BLK_W-1:0]   base_q, base_d;
  logic               wr_q, wr_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_last_q, rsp_last_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic [BEAT_W-1:0]  beat_nxt_s;
  logic               mem_we_s;
  logic [ADDR_W-1:0]  rd_addr_s;
  logic [DATA_W-1:0]  rd_data_s;

  data_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk       (clk),
    .wr_en_i   (mem_we_s),
    .wr_addr_i (req_addr),
    .wr_data_i (req_wdata),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (rd_data_s)
  );

  // Next-state, counters, memory port control and registered-output values.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    base_d      = base_q;
    wr_d        = wr_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_last_d  = rsp_last_q;
    rsp_data_d  = rsp_data_q;
    mem_we_s    = 1'b0;
    beat_nxt_s  = beat_q + BEAT_W'(1);
    // Output data is registered, so the array is addressed one beat ahead.
    rd_addr_s   = {base_q, beat_nxt_s};

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_WAIT;
          lat_d       = LAT_INIT;
          beat_d      = BEAT_ZERO;
          wr_d        = req_write;
          req_ready_d = 1'b0;
          if (req_write) begin
            mem_we_s = 1'b1;
          end else begin
            base_d = block_base(req_addr);
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end

      ST_WAIT: begin
        rd_addr_s = {base_q, BEAT_ZERO};
        if (lat_q == 4'd0) begin
          rsp_valid_d = 1'b1;
          if (wr_q) begin
            state_d    = ST_WACK;
            rsp_data_d = {DATA_W{1'b0}};
            rsp_last_d = 1'b1;
          end else begin
            state_d    = ST_BURST;
            rsp_data_d = rd_data_s;
            rsp_last_d = (LAST_BEAT == BEAT_ZERO);
          end
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end

      ST_BURST: begin
        if (rsp_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d     = ST_IDLE;
            beat_d      = BEAT_ZERO;
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
            rsp_data_d  = {DATA_W{1'b0}};
          end else begin
            beat_d     = beat_nxt_s;
            rsp_data_d = rd_data_s;
            rsp_last_d = (beat_nxt_s == LAST_BEAT);
          end
        end else begin
          beat_d = beat_q;
        end
      end

      ST_WACK: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          rsp_data_d  = {DATA_W{1'b0}};
        end else begin
          state_d = ST_WACK;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        lat_d       = 4'd0;
        beat_d      = BEAT_ZERO;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_data_d  = {DATA_W{1'b0}};
      end
    endcase
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lat_q       <= 4'd0;
      beat_q      <= BEAT_ZERO;
      base_q      <= {BLK_W{1'b0}};
      wr_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      wr_q        <= wr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed plus randomized traffic against a sparse
// memory model, on a LATENCY=4 instance and a LATENCY=1 instance.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [14:0] req_addr  = 15'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b1;

  logic        rr4, rv4, rl4, rr1, rv1, rl1;
  logic [31:0] rd4, rd1;
  logic        rr, rv, rl;
  logic [31:0] rd;
  logic        req_valid4, req_valid1;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [int];

  assign req_valid4 = req_valid && (sel == 1'b0);
  assign req_valid1 = req_valid && (sel == 1'b1);
  assign rr = sel ? rr1 : rr4;
  assign rv = sel ? rv1 : rv4;
  assign rl = sel ? rl1 : rl4;
  assign rd = sel ? rd1 : rd4;

  data_mem_responder #(.LATENCY(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(rr4),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_data(rd4), .rsp_last(rl4)
  );

  data_mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(rr1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1), .rsp_last(rl1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int key(input logic [14:0] a);
    return (sel ? 32768 : 0) + int'(a);
  endfunction

  function automatic int lat();
    return sel ? 1 : 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [14:0] addr, input logic [31:0] data, input int stall);
    chk_bit("wr_idle_ready", rr, 1'b1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    mdl[key(addr)] = data;
    chk_bit("wr_busy_ready", rr, 1'b0);
    chk_bit("wr_wait_valid", rv, 1'b0);
    for (int i = 1; i < lat(); i++) begin
      tick();
      chk_bit("wr_wait_valid", rv, 1'b0);
    end
    tick();
    chk_bit("wack_valid", rv, 1'b1);
    chk_bit("wack_last", rl, 1'b1);
    chk("wack_data", rd, 32'd0);
    if (stall > 0) begin
      rsp_ready = 1'b0;
      repeat (stall) begin
        tick();
        chk_bit("wack_hold_valid", rv, 1'b1);
        chk_bit("wack_hold_last", rl, 1'b1);
      end
      rsp_ready = 1'b1;
    end
    tick();
    chk_bit("wr_done_valid", rv, 1'b0);
    chk_bit("wr_done_ready", rr, 1'b1);
  endtask

  // hold_req keeps a conflicting write request asserted during the burst.
  task automatic do_read(input logic [14:0] addr, input int stall_beat, input int stall_n,
                         input bit hold_req);
    logic [14:0] base;
    logic [31:0] exp;
    base = addr & 15'h7FFC;
    chk_bit("rd_idle_ready", rr, 1'b1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    tick();
    if (hold_req) begin
      req_write = 1'b1; req_addr = base + 15'd1; req_wdata = 32'hBAD0_BAD0;
    end else begin
      req_valid = 1'b0;
    end
    chk_bit("rd_busy_ready", rr, 1'b0);
    chk_bit("rd_wait_valid", rv, 1'b0);
    for (int i = 1; i < lat(); i++) begin
      tick();
      chk_bit("rd_wait_valid", rv, 1'b0);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      exp = mdl[key(base + 15'(b))];
      chk_bit("beat_valid", rv, 1'b1);
      chk_bit("beat_ready_low", rr, 1'b0);
      chk("beat_data", rd, exp);
      chk_bit("beat_last", rl, (b == 3));
      if (b == stall_beat) begin
        rsp_ready = 1'b0;
        repeat (stall_n) begin
          tick();
          chk_bit("stall_valid", rv, 1'b1);
          chk("stall_data", rd, exp);
          chk_bit("stall_last", rl, (b == 3));
        end
        rsp_ready = 1'b1;
      end
      if (b == 3) begin
        req_valid = 1'b0; req_write = 1'b0;
      end
      tick();
    end
    chk_bit("rd_done_valid", rv, 1'b0);
    chk_bit("rd_done_ready", rr, 1'b1);
  endtask

  initial begin
    logic [14:0] a;
    logic [31:0] d;

    // Asynchronous reset with no clock edge.
    #2 rst = 1'b1;
    #1;
    chk_bit("rst_ready", rr, 1'b1);
    chk_bit("rst_valid", rv, 1'b0);
    chk_bit("rst_last", rl, 1'b0);
    chk("rst_data", rd, 32'd0);
    #4 rst = 1'b0;
    tick();

    // Writes then a block read from the middle of the block.
    for (int i = 0; i < 4; i++) do_write(15'h0100 + 15'(i), 32'hA0 + 32'(i), 0);
    do_read(15'h0102, 9, 0, 1'b0);
    do_read(15'h0102, 1, 3, 1'b0);

    // Top block, with block 0 holding distinct data to expose any wrap.
    for (int i = 0; i < 4; i++) do_write(15'h0000 + 15'(i), 32'h5500_0000 + 32'(i), 0);
    for (int i = 0; i < 3; i++) do_write(15'h7FFC + 15'(i), $urandom, 1);
    do_write(15'h7FFF, 32'hDEADBEEF, 0);
    chk("top_model", mdl[key(15'h7FFF)], 32'hDEADBEEF);
    do_read(15'h7FFD, 3, 2, 1'b0);

    // Reset in the middle of a burst.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0100;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    chk("mid_beat0", rd, 32'hA0);
    tick();
    chk("mid_beat1", rd, 32'hA1);
    #2 rst = 1'b1;
    #1;
    chk_bit("mid_rst_valid", rv, 1'b0);
    chk_bit("mid_rst_ready", rr, 1'b1);
    chk_bit("mid_rst_last", rl, 1'b0);
    #2 rst = 1'b0;
    do_read(15'h0100, 9, 0, 1'b0);

    // Request held during a burst must be ignored (no write, no new burst).
    do_read(15'h0100, 2, 1, 1'b1);
    tick();
    chk_bit("ignored_no_rsp", rv, 1'b0);
    do_read(15'h0101, 9, 0, 1'b0);

    // Randomized writes, overwrites and reads.
    for (int it = 0; it < 24; it++) begin
      a = 15'($urandom_range(0, 32767)) & 15'h7FFC;
      for (int i = 0; i < 4; i++) do_write(a + 15'(i), $urandom, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        do_write(a + 15'($urandom_range(0, 3)), d, 0);
      end
      do_read(a | 15'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 3)), 1'b0);
    end

    // LATENCY=1 instance.
    sel = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) do_write(15'h0100 + 15'(i), 32'hB0 + 32'(i), 0);
    do_read(15'h0101, 9, 0, 1'b0);
    for (int it = 0; it < 6; it++) begin
      a = 15'($urandom_range(0, 32767)) & 15'h7FFC;
      for (int i = 0; i < 4; i++) do_write(a + 15'(i), $urandom, 0);
      do_read(a | 15'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
